// File: rtl/one_by_three_demux_router.sv
// one_by_three_demux_router
//
// Registered 1-to-3 demultiplexer. Each word on the single valid/ready input stream
// is steered to output A, B or C by {sel1, sel2}: 00 -> A, 01 -> B, 1x -> C.
// Each output has a one-entry holding register with its own EMPTY/FULL FSM. A stalled
// output therefore only blocks words aimed at it; traffic to the other outputs
// keeps flowing.
//
// Ports
//   clk, rst                 clock and synchronous active-high reset
//   in_data/in_valid/in_ready   input stream; sel1/sel2 are sampled with in_data
//   A/B/C, *_valid, *_ready  output streams; data and valid come straight from registers
//   cnt_A/B/C                per-output drain counters, CNT_W bits, wrapping
//                            (present only when ROUTE_COUNT_EN is defined)
//
// Configuration macro: ROUTE_COUNT_EN adds the drain counters and their ports.

module one_by_three_demux_router #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             sel1,
  input  logic             sel2,
  output logic [WIDTH-1:0] A,
  output logic             A_valid,
  input  logic             A_ready,
  output logic [WIDTH-1:0] B,
  output logic             B_valid,
  input  logic             B_ready,
  output logic [WIDTH-1:0] C,
  output logic             C_valid,
  input  logic             C_ready
`ifdef ROUTE_COUNT_EN
  ,
  output logic [CNT_W-1:0] cnt_A,
  output logic [CNT_W-1:0] cnt_B,
  output logic [CNT_W-1:0] cnt_C
`endif
);

  localparam logic StEmpty = 1'b0;
  localparam logic StFull  = 1'b1;

  // Index 0/1/2 corresponds to output A/B/C throughout.
  logic [2:0]            full_q, full_d;
  logic [2:0][WIDTH-1:0] data_q, data_d;
  logic [2:0]            out_ready;
  logic [1:0]            tgt;
  logic [2:0]            tgt_oh;
  logic                  accept;

  assign out_ready = {C_ready, B_ready, A_ready};

  // Target decode; sel1 high selects C regardless of sel2, so tgt never reaches 3.
  always_comb begin
    tgt    = sel1 ? 2'd2 : {1'b0, sel2};
    tgt_oh = 3'b001 << tgt;
  end

  // The target can take a word when it is empty or is being drained this cycle.
  assign in_ready = !rst && ((full_q[tgt] == StEmpty) || out_ready[tgt]);
  assign accept   = in_valid && in_ready;

  always_comb begin
    full_d = full_q;
    data_d = data_q;
    for (int i = 0; i < 3; i++) begin
      unique case (full_q[i])
        StEmpty: begin
          if (accept && tgt_oh[i]) begin
            full_d[i] = StFull;
            data_d[i] = in_data;
          end
        end
        StFull: begin
          if (accept && tgt_oh[i]) begin
            // Drain and reload in the same cycle: no bubble.
            data_d[i] = in_data;
          end else if (out_ready[i]) begin
            full_d[i] = StEmpty;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      full_q <= '0;
      data_q <= '0;
    end else begin
      full_q <= full_d;
      data_q <= data_d;
    end
  end

  assign A       = data_q[0];
  assign B       = data_q[1];
  assign C       = data_q[2];
  assign A_valid = (full_q[0] == StFull);
  assign B_valid = (full_q[1] == StFull);
  assign C_valid = (full_q[2] == StFull);

`ifdef ROUTE_COUNT_EN
  logic [2:0]            drain;
  logic [2:0][CNT_W-1:0] cnt_q;

  assign drain = full_q & out_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      for (int i = 0; i < 3; i++) begin
        if (drain[i]) cnt_q[i] <= cnt_q[i] + CNT_W'(1);
      end
    end
  end

  assign cnt_A = cnt_q[0];
  assign cnt_B = cnt_q[1];
  assign cnt_C = cnt_q[2];
`else
  logic unused_cnt_w;
  assign unused_cnt_w = (CNT_W != 0);
`endif

endmodule

// File: tb/tb_one_by_three_demux_router.sv
// Bench for one_by_three_demux_router. A queue-per-output model (capacity one word each)
// predicts in_ready, valids and data; a negedge process compares every cycle. Directed
// sequences add hand-computed literal expectations.

module tb_one_by_three_demux_router;

  localparam int W  = 8;
  localparam int CW = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic [W-1:0] in_data;
  logic         in_valid;
  logic         in_ready;
  logic         sel1, sel2;
  logic [W-1:0] A, B, C;
  logic         A_valid, B_valid, C_valid;
  logic         A_ready, B_ready, C_ready;
`ifdef ROUTE_COUNT_EN
  logic [CW-1:0] cnt_A, cnt_B, cnt_C;
`endif

  always #5 clk = ~clk;

  one_by_three_demux_router #(
    .WIDTH(W),
    .CNT_W(CW)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .in_data (in_data),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .sel1    (sel1),
    .sel2    (sel2),
    .A       (A),
    .A_valid (A_valid),
    .A_ready (A_ready),
    .B       (B),
    .B_valid (B_valid),
    .B_ready (B_ready),
    .C       (C),
    .C_valid (C_valid),
    .C_ready (C_ready)
`ifdef ROUTE_COUNT_EN
    ,
    .cnt_A   (cnt_A),
    .cnt_B   (cnt_B),
    .cnt_C   (cnt_C)
`endif
  );

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- model ----------------
  logic [W-1:0] mq [3][$];
  int unsigned  mcnt [3];
  bit           started = 1'b0;

  function automatic int tgt_of(input logic s1, input logic s2);
    return s1 ? 2 : (s2 ? 1 : 0);
  endfunction

  function automatic logic rdy_of(input int i);
    return (i == 0) ? A_ready : (i == 1) ? B_ready : C_ready;
  endfunction

  function automatic logic vld_of(input int i);
    return (i == 0) ? A_valid : (i == 1) ? B_valid : C_valid;
  endfunction

  function automatic logic [W-1:0] dat_of(input int i);
    return (i == 0) ? A : (i == 1) ? B : C;
  endfunction

  function automatic logic exp_in_ready();
    int t;
    if (rst) return 1'b0;
    t = tgt_of(sel1, sel2);
    return (mq[t].size() == 0) || rdy_of(t);
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 3; i++) begin
        mq[i].delete();
        mcnt[i] = 0;
      end
      started = 1'b1;
    end else begin
      logic acc;
      int   t;
      acc = in_valid && exp_in_ready();
      t   = tgt_of(sel1, sel2);
      for (int i = 0; i < 3; i++) begin
        if (mq[i].size() > 0 && rdy_of(i)) begin
          void'(mq[i].pop_front());
          mcnt[i]++;
        end
      end
      if (acc) mq[t].push_back(in_data);
    end
  end

  always @(negedge clk) begin
    if (started) begin
      chk("m_in_ready", {31'b0, in_ready}, {31'b0, exp_in_ready()});
      for (int i = 0; i < 3; i++) begin
        chk($sformatf("m_valid%0d", i), {31'b0, vld_of(i)}, {31'b0, mq[i].size() > 0});
        if (mq[i].size() > 0) chk($sformatf("m_data%0d", i), {24'b0, dat_of(i)}, {24'b0, mq[i][0]});
      end
`ifdef ROUTE_COUNT_EN
      chk("m_cnt_A", {28'b0, cnt_A}, mcnt[0] % 16);
      chk("m_cnt_B", {28'b0, cnt_B}, mcnt[1] % 16);
      chk("m_cnt_C", {28'b0, cnt_C}, mcnt[2] % 16);
`endif
    end
  end

  // ---------------- stimulus ----------------
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic s1, input logic s2, input logic [W-1:0] d);
    sel1     = s1;
    sel2     = s2;
    in_data  = d;
    in_valid = 1'b1;
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b1; in_data = 8'hEE; sel1 = 1'b0; sel2 = 1'b0;
    A_ready = 1'b1; B_ready = 1'b1; C_ready = 1'b1;

    // Reset held two clocks with in_valid high.
    cyc(); cyc();
    chk("rst_in_ready", {31'b0, in_ready}, 32'd0);
    chk("rst_A_valid", {31'b0, A_valid}, 32'd0);
    chk("rst_B_valid", {31'b0, B_valid}, 32'd0);
    chk("rst_C_valid", {31'b0, C_valid}, 32'd0);
    chk("rst_A", {24'b0, A}, 32'h0);
    chk("rst_B", {24'b0, B}, 32'h0);
    chk("rst_C", {24'b0, C}, 32'h0);
    rst = 1'b0; in_valid = 1'b0;
    cyc();

    // Basic routing, all outputs ready.
    send(1'b0, 1'b0, 8'h11); cyc();
    chk("t2_A_valid", {31'b0, A_valid}, 32'd1);
    chk("t2_A", {24'b0, A}, 32'h11);
    send(1'b0, 1'b1, 8'h22); cyc();
    chk("t2_B", {24'b0, B}, 32'h22);
    chk("t2_A_drained", {31'b0, A_valid}, 32'd0);
    send(1'b1, 1'b0, 8'h33); cyc();
    chk("t2_C1", {24'b0, C}, 32'h33);
    send(1'b1, 1'b1, 8'h44); cyc();
    chk("t2_C2_valid", {31'b0, C_valid}, 32'd1);
    chk("t2_C2", {24'b0, C}, 32'h44);
    in_valid = 1'b0; cyc();
    chk("t2_C_drained", {31'b0, C_valid}, 32'd0);

    // A stalled; B traffic still flows.
    A_ready = 1'b0;
    send(1'b0, 1'b0, 8'h5A); cyc();
    chk("t3_A1", {24'b0, A}, 32'h5A);
    send(1'b0, 1'b0, 8'h5B); #1;
    chk("t3_blocked", {31'b0, in_ready}, 32'd0);
    cyc();
    chk("t3_A_held", {24'b0, A}, 32'h5A);
    send(1'b0, 1'b1, 8'h66); #1;
    chk("t3_B_ready", {31'b0, in_ready}, 32'd1);
    cyc();
    chk("t3_B", {24'b0, B}, 32'h66);
    chk("t3_A_still", {24'b0, A}, 32'h5A);
    A_ready = 1'b1;
    send(1'b0, 1'b0, 8'h5B); cyc();
    chk("t3_A2_valid", {31'b0, A_valid}, 32'd1);
    chk("t3_A2", {24'b0, A}, 32'h5B);
    in_valid = 1'b0; cyc();
    chk("t3_A_drained", {31'b0, A_valid}, 32'd0);

    // C full and draining while a new word arrives: reload without a bubble.
    C_ready = 1'b0;
    send(1'b1, 1'b0, 8'h70); cyc();
    chk("t4_C0", {24'b0, C}, 32'h70);
    C_ready = 1'b1;
    send(1'b1, 1'b1, 8'h77); #1;
    chk("t4_ready", {31'b0, in_ready}, 32'd1);
    cyc();
    chk("t4_C_valid", {31'b0, C_valid}, 32'd1);
    chk("t4_C", {24'b0, C}, 32'h77);
    in_valid = 1'b0; cyc();
    chk("t4_C_drained", {31'b0, C_valid}, 32'd0);

    // Mixed targets with a rotating ready pattern; checked by the model.
    for (int k = 0; k < 24; k++) begin
      A_ready = k[0];
      B_ready = k[1];
      C_ready = (k % 3) != 0;
      send(k[2], k[0] ^ k[3], 8'(8'h80 + k));
      in_valid = (k % 5) != 4;
      cyc();
    end
    in_valid = 1'b0; A_ready = 1'b1; B_ready = 1'b1; C_ready = 1'b1;
    cyc(); cyc();

    // Reset drops a held word.
    A_ready = 1'b0;
    send(1'b0, 1'b0, 8'h99); cyc();
    chk("t5_A_full", {24'b0, A}, 32'h99);
    in_valid = 1'b0; rst = 1'b1; cyc();
    chk("t5_A_valid", {31'b0, A_valid}, 32'd0);
    chk("t5_A", {24'b0, A}, 32'h0);
    rst = 1'b0; cyc();
    chk("t5_A_lost", {31'b0, A_valid}, 32'd0);
    A_ready = 1'b1;

    // 17 back-to-back words to B at one per clock.
    for (int k = 0; k < 17; k++) begin
      send(1'b0, 1'b1, 8'(k + 1));
      cyc();
      chk("t6_B", {24'b0, B}, k + 1);
    end
    in_valid = 1'b0; cyc();
`ifdef ROUTE_COUNT_EN
    chk("t6_cnt_B", {28'b0, cnt_B}, 32'd1);
    chk("t6_cnt_A", {28'b0, cnt_A}, 32'd0);
    chk("t6_cnt_C", {28'b0, cnt_C}, 32'd0);
`endif
    cyc();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
